prog_counter: RTL and testbench
===============================

# prog_counter

Parametrised programmable counter, successor to the team's basic clear/increment/set counter. Adds up/down direction, a variable step, a programmable limit, and three boundary modes: wrap, saturate, and one-shot. It also provides terminal-count, overflow and done status. It serves as a general address/beat/timeout counter wherever the datapath needs a modulus other than 2^WIDTH.

## Interface
- WIDTH, 8, counter and limit width
- STEP_W, 4, width of step input
- RESET_VAL, 0, value of d_out after reset and after sclr
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- sclr  input  1  synchronous clear, highest synchronous priority
- load  input  1  synchronous load of d_in
- d_in  input  WIDTH  load value
- en  input  1  count enable
- dir  input  1  1 = up, 0 = down
- step  input  STEP_W  increment/decrement amount, zero-extended
- mode  input  2  00 FREE (wrap), 01 SAT, 10 ONESHOT, 11 reserved (behaves as FREE)
- limit  input  WIDTH  inclusive upper bound; count range is 0..limit
- d_out  output  WIDTH  counter value, registered
- tc  output  1  terminal-count pulse, registered
- ovf  output  1  sticky overflow/underflow flag
- done  output  1  one-shot completed
- busy  output  1  one-shot running

## Operation
- Priority per cycle is sclr > load > count.
- sclr: d_out=RESET_VAL, ovf=0, state=IDLE.
- load: d_out=d_in, ovf=0. In ONESHOT, state goes to RUN; in other modes state stays IDLE.
- Count occurs when en=1, neither sclr nor load is active, and (mode!=ONESHOT or state==RUN). With step=0 or en=0, all outputs hold except that tc deasserts.
- Arithmetic is performed in WIDTH+1 bits; limit and mode are sampled every cycle.
- Up, sum=d_out+step:
  - sum<limit: d_out=sum.
  - sum==limit: d_out=limit, tc=1.
  - sum>limit: tc=1, ovf=1. FREE: d_out=sum-limit-1, except that if d_out>limit beforehand (loaded above limit), d_out=0. SAT/ONESHOT: d_out=limit.
- Down:
  - d_out>step: d_out=d_out-step.
  - d_out==step: d_out=0, tc=1.
  - d_out<step: tc=1, ovf=1. FREE: d_out=d_out+limit+1-step. SAT/ONESHOT: d_out=0.
- SAT holding at a bound pulses tc on every enabled count attempt.
- FSM states are IDLE, RUN and DONE (one-shot only):
  - IDLE to RUN on load in ONESHOT.
  - RUN to DONE on any count with tc=1.
  - DONE to RUN on load.
  - Any state to IDLE on sclr, or whenever mode!=ONESHOT.
  - In DONE, en is ignored.
- Status outputs: busy=(state==RUN), done=(state==DONE). Both are registered.

## Timing
- rst_n low asynchronously forces: d_out=RESET_VAL, tc=0, ovf=0, done=0, busy=0, state=IDLE. Release is synchronous to the next clk edge.
- One-cycle latency: inputs sampled at edge N appear on d_out/tc/ovf/done/busy after edge N.
- tc is high for exactly the cycle whose d_out was produced by the terminal count.
- ovf rises in the same cycle as the wrap or saturation that causes it.
- Reset mid-run abandons the one-shot with no done pulse.
- A mode change takes effect on the cycle it is sampled.

## Structure
- Shared package ctr_pkg holds:
  - typedef enum ctr_mode_e {CTR_FREE=2'b00, CTR_SAT=2'b01, CTR_ONESHOT=2'b10}.
  - typedef enum ctr_state_e {ST_IDLE, ST_RUN, ST_DONE}.
- One combinational sub-module, ctr_next, computes next value, tc and ovf from d_out/step/dir/limit/mode. The top level holds registers and the FSM.

## Test plan
All cases use WIDTH=8 and STEP_W=4.

- Reset: count to 5, assert rst_n=0 between edges. Required: d_out=0, flags=0 immediately without a clock.
- FREE up, limit=9, step=3, load 8, en=1. Required: next d_out=1, tc=1, ovf=1. Then 4, tc=0, ovf still 1. load 2 clears ovf.
- SAT down, limit=9, step=2, load 3, en held. Required: 1, then 0 with tc=1 and ovf=1, then 0 with tc=1 on every following cycle.
- ONESHOT up, limit=4, step=1, load 0. Required: busy=1. After 4 en cycles d_out=4, tc=1, done=1, busy=0. Further en leaves d_out=4. sclr gives d_out=0, done=0.
- Priority: sclr+load+en with d_in=7 gives d_out=0. load+en with d_in=7 gives d_out=7 with no count that cycle.
- Edge cases:
  - step=0 with en=1 holds d_out and keeps tc=0.
  - load 12 with limit=9 in FREE, then one up count, gives d_out=0, tc=1, ovf=1.

Source files
------------

// File: rtl/ctr_pkg.sv
// Shared types for the programmable counter: boundary modes and one-shot states.
package ctr_pkg;

  typedef enum logic [1:0] {
    CTR_FREE    = 2'b00,
    CTR_SAT     = 2'b01,
    CTR_ONESHOT = 2'b10
  } ctr_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } ctr_state_e;

endpackage

// File: rtl/ctr_next.sv
// Combinational next-value logic: one up/down step against an inclusive limit,
// with wrap or clamp behaviour at the bounds and the matching tc/ovf flags.
module ctr_next
  import ctr_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STEP_W = 4
) (
  input  logic [WIDTH-1:0]  cur,
  input  logic [STEP_W-1:0] step,
  input  logic              dir,
  input  logic [WIDTH-1:0]  limit,
  input  logic [1:0]        mode,
  output logic [WIDTH-1:0]  nxt,
  output logic              tc,
  output logic              ovf
);

  // Everything is widened by one bit so the sums and compares cannot overflow.
  logic [WIDTH:0] cur_x;
  logic [WIDTH:0] step_x;
  logic [WIDTH:0] lim_x;
  logic [WIDTH:0] one_x;
  logic [WIDTH:0] sum_x;
  logic [WIDTH:0] up_wrap_x;
  logic [WIDTH:0] dn_diff_x;
  logic [WIDTH:0] dn_wrap_x;
  logic           clamp;

  assign cur_x     = {1'b0, cur};
  assign step_x    = {{(WIDTH + 1 - STEP_W){1'b0}}, step};
  assign lim_x     = {1'b0, limit};
  assign one_x     = {{WIDTH{1'b0}}, 1'b1};
  assign sum_x     = cur_x + step_x;
  assign up_wrap_x = sum_x - lim_x - one_x;
  assign dn_diff_x = cur_x - step_x;
  assign dn_wrap_x = cur_x + lim_x + one_x - step_x;
  assign clamp     = (mode == CTR_SAT) || (mode == CTR_ONESHOT);

  // Pick the result for the current direction; the reserved mode falls into the wrap path.
  always_comb begin
    nxt = cur;
    tc  = 1'b0;
    ovf = 1'b0;
    if (dir) begin
      if (sum_x < lim_x) begin
        nxt = sum_x[WIDTH-1:0];
      end else if (sum_x == lim_x) begin
        nxt = limit;
        tc  = 1'b1;
      end else begin
        tc  = 1'b1;
        ovf = 1'b1;
        if (clamp) begin
          nxt = limit;
        end else if (cur_x > lim_x) begin
          nxt = '0;
        end else begin
          nxt = up_wrap_x[WIDTH-1:0];
        end
      end
    end else begin
      if (cur_x > step_x) begin
        nxt = dn_diff_x[WIDTH-1:0];
      end else if (cur_x == step_x) begin
        nxt = '0;
        tc  = 1'b1;
      end else begin
        tc  = 1'b1;
        ovf = 1'b1;
        if (clamp) begin
          nxt = '0;
        end else begin
          nxt = dn_wrap_x[WIDTH-1:0];
        end
      end
    end
  end

endmodule

// File: rtl/prog_counter.sv
// Programmable up/down counter with limit, wrap/saturate/one-shot modes and status flags.
module prog_counter
  import ctr_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter int               STEP_W    = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sclr,
  input  logic              load,
  input  logic [WIDTH-1:0]  d_in,
  input  logic              en,
  input  logic              dir,
  input  logic [STEP_W-1:0] step,
  input  logic [1:0]        mode,
  input  logic [WIDTH-1:0]  limit,
  output logic [WIDTH-1:0]  d_out,
  output logic              tc,
  output logic              ovf,
  output logic              done,
  output logic              busy
);

  ctr_state_e       state;
  ctr_state_e       state_nxt;
  logic [WIDTH-1:0] d_out_nxt;
  logic             tc_nxt;
  logic             ovf_nxt;
  logic [WIDTH-1:0] cnt_val;
  logic             cnt_tc;
  logic             cnt_ovf;
  logic             oneshot;
  logic             do_count;

  ctr_next #(
    .WIDTH  (WIDTH),
    .STEP_W (STEP_W)
  ) u_next (
    .cur   (d_out),
    .step  (step),
    .dir   (dir),
    .limit (limit),
    .mode  (mode),
    .nxt   (cnt_val),
    .tc    (cnt_tc),
    .ovf   (cnt_ovf)
  );

  assign oneshot  = (mode == CTR_ONESHOT);
  // A zero step is treated as no count so that tc drops and nothing else moves.
  assign do_count = en && !sclr && !load && (step != '0) &&
                    (!oneshot || (state == ST_RUN));

  // Next state and next register values, applying sclr > load > count priority.
  always_comb begin
    state_nxt = state;
    d_out_nxt = d_out;
    tc_nxt    = 1'b0;
    ovf_nxt   = ovf;

    if (sclr) begin
      d_out_nxt = RESET_VAL;
      ovf_nxt   = 1'b0;
    end else if (load) begin
      d_out_nxt = d_in;
      ovf_nxt   = 1'b0;
    end else if (do_count) begin
      d_out_nxt = cnt_val;
      tc_nxt    = cnt_tc;
      ovf_nxt   = ovf | cnt_ovf;
    end

    if (sclr || !oneshot) begin
      state_nxt = ST_IDLE;
    end else if (load) begin
      state_nxt = ST_RUN;
    end else if (do_count && cnt_tc) begin
      state_nxt = ST_DONE;
    end
  end

  // Counter, flag and FSM registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      d_out <= RESET_VAL;
      tc    <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      state <= state_nxt;
      d_out <= d_out_nxt;
      tc    <= tc_nxt;
      ovf   <= ovf_nxt;
    end
  end

  assign busy = (state == ST_RUN);
  assign done = (state == ST_DONE);

endmodule

// File: tb/tb_prog_counter.sv
// Directed bench for prog_counter: the driver pushes hand-computed expectations into a
// queue and a separate monitor pops and compares them when the DUT updates.
module tb_prog_counter;
  import ctr_pkg::*;

  typedef struct {
    string      name;
    logic [7:0] d;
    logic       tc;
    logic       ovf;
    logic       done;
    logic       busy;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sclr = 1'b0;
  logic       load = 1'b0;
  logic [7:0] d_in = 8'd0;
  logic       en = 1'b0;
  logic       dir = 1'b1;
  logic [3:0] step = 4'd1;
  logic [1:0] mode = 2'b00;
  logic [7:0] limit = 8'd9;
  logic [7:0] d_out;
  logic       tc;
  logic       ovf;
  logic       done;
  logic       busy;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;

  localparam logic [1:0] F = CTR_FREE;
  localparam logic [1:0] S = CTR_SAT;
  localparam logic [1:0] O = CTR_ONESHOT;
  localparam logic [1:0] R = 2'b11;

  prog_counter #(
    .WIDTH     (8),
    .STEP_W    (4),
    .RESET_VAL (8'd0)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sclr  (sclr),
    .load  (load),
    .d_in  (d_in),
    .en    (en),
    .dir   (dir),
    .step  (step),
    .mode  (mode),
    .limit (limit),
    .d_out (d_out),
    .tc    (tc),
    .ovf   (ovf),
    .done  (done),
    .busy  (busy)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  // Compare one expectation against the current DUT outputs.
  task automatic checkOutput(input exp_t e);
    n_checks++;
    if (d_out !== e.d || tc !== e.tc || ovf !== e.ovf || done !== e.done || busy !== e.busy) begin
      n_fail++;
      $display("[TB] FAIL %s: got d_out=%0d tc=%0b ovf=%0b done=%0b busy=%0b, expected d_out=%0d tc=%0b ovf=%0b done=%0b busy=%0b",
               e.name, d_out, tc, ovf, done, busy, e.d, e.tc, e.ovf, e.done, e.busy);
    end
  endtask

  // Drive one cycle of inputs on the falling edge and queue what the next rising edge must produce.
  task automatic applyStimulus(input string nm, input logic s, input logic l, input logic [7:0] di,
                               input logic e, input logic dr, input logic [3:0] st,
                               input logic [1:0] md, input logic [7:0] lim,
                               input logic [7:0] xd, input logic xtc, input logic xovf,
                               input logic xdone, input logic xbusy);
    exp_t item;
    @(negedge clk);
    sclr  = s;
    load  = l;
    d_in  = di;
    en    = e;
    dir   = dr;
    step  = st;
    mode  = md;
    limit = lim;
    item.name = nm;
    item.d    = xd;
    item.tc   = xtc;
    item.ovf  = xovf;
    item.done = xdone;
    item.busy = xbusy;
    exp_q.push_back(item);
  endtask

  // Pulse rst_n low between clock edges; the monitor checks the asynchronous effect.
  task automatic applyReset(input string nm);
    exp_t item;
    @(negedge clk);
    sclr = 1'b0;
    load = 1'b0;
    en   = 1'b0;
    item.name = nm;
    item.d    = 8'd0;
    item.tc   = 1'b0;
    item.ovf  = 1'b0;
    item.done = 1'b0;
    item.busy = 1'b0;
    exp_q.push_back(item);
    #2 rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: after every update (clock edge or asynchronous reset) pop and compare.
  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      #1;
      if (exp_q.size() > 0) checkOutput(exp_q.pop_front());
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete, expected completion");
    $fatal(1, "[TB] timeout");
  end

  // Directed stimulus.
  initial begin
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    applyStimulus("rst_state", 0, 0, 0, 0, 1, 1, F, 9, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 5; i++)
      applyStimulus("cnt_to5", 0, 0, 0, 1, 1, 1, F, 9, 8'(i), 0, 0, 0, 0);
    applyReset("async_rst");

    applyStimulus("free_ld8",   0, 1, 8,  1, 1, 3, F, 9, 8,  0, 0, 0, 0);
    applyStimulus("free_wrap",  0, 0, 0,  1, 1, 3, F, 9, 1,  1, 1, 0, 0);
    applyStimulus("free_after", 0, 0, 0,  1, 1, 3, F, 9, 4,  0, 1, 0, 0);
    applyStimulus("free_ld2",   0, 1, 2,  0, 1, 3, F, 9, 2,  0, 0, 0, 0);
    applyStimulus("free_ld6",   0, 1, 6,  0, 1, 3, F, 9, 6,  0, 0, 0, 0);
    applyStimulus("free_eq",    0, 0, 0,  1, 1, 3, F, 9, 9,  1, 0, 0, 0);
    applyStimulus("step0",      0, 0, 0,  1, 1, 0, F, 9, 9,  0, 0, 0, 0);
    applyStimulus("ld_above",   0, 1, 12, 0, 1, 1, F, 9, 12, 0, 0, 0, 0);
    applyStimulus("above_cnt",  0, 0, 0,  1, 1, 1, F, 9, 0,  1, 1, 0, 0);

    applyStimulus("fdn_ld1",    0, 1, 1,  0, 0, 3, F, 9, 1,  0, 0, 0, 0);
    applyStimulus("fdn_wrap",   0, 0, 0,  1, 0, 3, F, 9, 8,  1, 1, 0, 0);
    applyStimulus("fdn_5",      0, 0, 0,  1, 0, 3, F, 9, 5,  0, 1, 0, 0);
    applyStimulus("fdn_2",      0, 0, 0,  1, 0, 3, F, 9, 2,  0, 1, 0, 0);
    applyStimulus("fdn_wrap2",  0, 0, 0,  1, 0, 3, F, 9, 9,  1, 1, 0, 0);

    applyStimulus("sat_ld3",    0, 1, 3,  1, 0, 2, S, 9, 3,  0, 0, 0, 0);
    applyStimulus("sat_1",      0, 0, 0,  1, 0, 2, S, 9, 1,  0, 0, 0, 0);
    applyStimulus("sat_0",      0, 0, 0,  1, 0, 2, S, 9, 0,  1, 1, 0, 0);
    applyStimulus("sat_hold1",  0, 0, 0,  1, 0, 2, S, 9, 0,  1, 1, 0, 0);
    applyStimulus("sat_hold2",  0, 0, 0,  1, 0, 2, S, 9, 0,  1, 1, 0, 0);
    applyStimulus("satup_ld8",  0, 1, 8,  0, 1, 3, S, 9, 8,  0, 0, 0, 0);
    applyStimulus("satup",      0, 0, 0,  1, 1, 3, S, 9, 9,  1, 1, 0, 0);
    applyStimulus("satup_en0",  0, 0, 0,  0, 1, 3, S, 9, 9,  0, 1, 0, 0);

    applyStimulus("rsv_ld8",    0, 1, 8,  0, 1, 3, R, 9, 8,  0, 0, 0, 0);
    applyStimulus("rsv_wrap",   0, 0, 0,  1, 1, 3, R, 9, 1,  1, 1, 0, 0);

    applyStimulus("os_ld0",     0, 1, 0,  0, 1, 1, O, 4, 0,  0, 0, 0, 1);
    applyStimulus("os_1",       0, 0, 0,  1, 1, 1, O, 4, 1,  0, 0, 0, 1);
    applyStimulus("os_2",       0, 0, 0,  1, 1, 1, O, 4, 2,  0, 0, 0, 1);
    applyStimulus("os_3",       0, 0, 0,  1, 1, 1, O, 4, 3,  0, 0, 0, 1);
    applyStimulus("os_4",       0, 0, 0,  1, 1, 1, O, 4, 4,  1, 0, 1, 0);
    applyStimulus("os_ign1",    0, 0, 0,  1, 1, 1, O, 4, 4,  0, 0, 1, 0);
    applyStimulus("os_ign2",    0, 0, 0,  1, 1, 1, O, 4, 4,  0, 0, 1, 0);
    applyStimulus("os_sclr",    1, 0, 0,  1, 1, 1, O, 4, 0,  0, 0, 0, 0);
    applyStimulus("os_idle",    0, 0, 0,  1, 1, 1, O, 4, 0,  0, 0, 0, 0);
    applyStimulus("os_ld2",     0, 1, 2,  0, 1, 1, O, 4, 2,  0, 0, 0, 1);
    applyStimulus("os_tofree",  0, 0, 0,  1, 1, 1, F, 4, 3,  0, 0, 0, 0);
    applyStimulus("os_ld3",     0, 1, 3,  0, 1, 3, O, 4, 3,  0, 0, 0, 1);
    applyStimulus("os_sat",     0, 0, 0,  1, 1, 3, O, 4, 4,  1, 1, 1, 0);
    applyStimulus("os_reld",    0, 1, 1,  0, 1, 1, O, 4, 1,  0, 0, 0, 1);
    applyStimulus("os_run",     0, 0, 0,  1, 1, 1, O, 4, 2,  0, 0, 0, 1);
    applyReset("rst_midrun");
    applyStimulus("os_postrst", 0, 0, 0,  1, 1, 1, O, 4, 0,  0, 0, 0, 0);

    applyStimulus("pr_ld5",     0, 1, 5,  0, 1, 1, F, 9, 5,  0, 0, 0, 0);
    applyStimulus("pr_all",     1, 1, 7,  1, 1, 1, F, 9, 0,  0, 0, 0, 0);
    applyStimulus("pr_ld_en",   0, 1, 7,  1, 1, 1, F, 9, 7,  0, 0, 0, 0);
    applyStimulus("pr_cnt",     0, 0, 0,  1, 1, 1, F, 9, 8,  0, 0, 0, 0);

    @(negedge clk);
    en = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
